controlador_operacao: RTL and testbench

Sequences the 3-bit ALU operation selector from the board push-buttons and switch. Raw KEY inputs are debounced. An edit/apply state machine lets the user step through candidate operations while the candidate blinks on the operation-symbol display. The chosen code is committed to the ALU only on confirmation. Outputs feed the ALU op input (OP_SEL) and the operation-symbol 7-segment decoder (DISP_SEL, DISP_BLANK).

---
 rtl/controlador_operacao_pkg.sv | 27 ++
 rtl/debounce_botao.sv | 52 +++++
 rtl/controlador_operacao.sv | 145 ++++++++++++++
 tb/tb_controlador_operacao.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/controlador_operacao_pkg.sv
// Shared definitions for the ALU operation selector: code width, controller
// states and the operation codes understood by the ALU and the symbol decoder.
package controlador_operacao_pkg;

    localparam int OP_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EDIT  = 2'd1,
        APPLY = 2'd2
    } estado_t;

    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_AND = 3'd2;
    localparam logic [OP_W-1:0] OP_OR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR = 3'd4;
    localparam logic [OP_W-1:0] OP_SHL = 3'd5;
    localparam logic [OP_W-1:0] OP_SHR = 3'd6;
    localparam logic [OP_W-1:0] OP_NOP = 3'd7;

    // Candidate after the current one; wraps 7 -> 0 through natural overflow.
    function automatic logic [OP_W-1:0] next_op(input logic [OP_W-1:0] op);
        return op + OP_W'(1);
    endfunction

endpackage

// File: rtl/debounce_botao.sv
// Push-button debouncer: 2-flop synchronizer, stability counter and a
// single-cycle pulse on each accepted press (stable level going 1 -> 0).
module debounce_botao #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic raw_n,
    output logic press_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             stable_reg;
    logic             stable_d_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             pulse_reg;

    // Synchronize, qualify the new level for DEBOUNCE_CYCLES cycles, then flag the press edge.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            sync1_reg    <= 1'b1;
            sync2_reg    <= 1'b1;
            stable_reg   <= 1'b1;
            stable_d_reg <= 1'b1;
            cnt_reg      <= '0;
            pulse_reg    <= 1'b0;
        end else begin
            sync1_reg    <= raw_n;
            sync2_reg    <= sync1_reg;
            stable_d_reg <= stable_reg;
            pulse_reg    <= stable_d_reg & ~stable_reg;
            if (sync2_reg != stable_reg) begin
                if (cnt_reg == CNT_LAST) begin
                    stable_reg <= sync2_reg;
                    cnt_reg    <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end else begin
                // Any bounce back to the accepted level restarts qualification.
                cnt_reg <= '0;
            end
        end
    end

    assign press_pulse = pulse_reg;

endmodule

// File: rtl/controlador_operacao.sv
// ALU operation selector: debounced KEY0 (confirm) / KEY1 (next) drive an
// IDLE/EDIT/APPLY controller; the candidate blinks while edited and reaches
// the ALU only on confirmation. All outputs are registered.
module controlador_operacao
    import controlador_operacao_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLINK_CYCLES    = 12500000,
    parameter int TIMEOUT_CYCLES  = 500000000
) (
    input  logic            CLOCK_50,
    input  logic            RESET_N,
    input  logic            KEY0,
    input  logic            KEY1,
    input  logic            SW9,
    output logic [OP_W-1:0] OP_SEL,
    output logic [OP_W-1:0] DISP_SEL,
    output logic            DISP_BLANK,
    output logic            OP_STROBE,
    output logic            EDITING
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);

    // Index 0 = KEY0 (confirm), index 1 = KEY1 (next).
    logic [1:0] keys_n;
    logic [1:0] press_pulse;

    assign keys_n = {KEY1, KEY0};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_deb
            debounce_botao #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .CLOCK_50   (CLOCK_50),
                .RESET_N    (RESET_N),
                .raw_n      (keys_n[gi]),
                .press_pulse(press_pulse[gi])
            );
        end
    endgenerate

    logic            press_conf;
    logic            press_next;

    assign press_conf = press_pulse[0];
    assign press_next = press_pulse[1];

    estado_t         state_reg;
    logic [OP_W-1:0] pending_reg;
    logic [OP_W-1:0] op_sel_reg;
    logic [OP_W-1:0] disp_sel_reg;
    logic            disp_blank_reg;
    logic            op_strobe_reg;
    logic            editing_reg;
    logic [TO_W-1:0] to_cnt_reg;
    logic [BL_W-1:0] bl_cnt_reg;

    // Edit/apply controller with registered outputs, blink and idle-timeout counters.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_reg      <= IDLE;
            pending_reg    <= OP_ADD;
            op_sel_reg     <= OP_ADD;
            disp_sel_reg   <= OP_ADD;
            disp_blank_reg <= 1'b0;
            op_strobe_reg  <= 1'b0;
            editing_reg    <= 1'b0;
            to_cnt_reg     <= '0;
            bl_cnt_reg     <= '0;
        end else begin
            op_strobe_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    disp_sel_reg   <= op_sel_reg;
                    disp_blank_reg <= 1'b0;
                    editing_reg    <= 1'b0;
                    if (press_next && !SW9) begin
                        state_reg    <= EDIT;
                        pending_reg  <= next_op(op_sel_reg);
                        disp_sel_reg <= next_op(op_sel_reg);
                        editing_reg  <= 1'b1;
                        to_cnt_reg   <= '0;
                        bl_cnt_reg   <= '0;
                    end
                end
                EDIT: begin
                    // Blink and timeout advance every cycle; exits below override.
                    to_cnt_reg <= to_cnt_reg + TO_W'(1);
                    if (bl_cnt_reg == BL_LAST) begin
                        bl_cnt_reg     <= '0;
                        disp_blank_reg <= ~disp_blank_reg;
                    end else begin
                        bl_cnt_reg <= bl_cnt_reg + BL_W'(1);
                    end
                    if (SW9) begin
                        state_reg      <= IDLE;
                        disp_sel_reg   <= op_sel_reg;
                        disp_blank_reg <= 1'b0;
                        editing_reg    <= 1'b0;
                    end else if (press_conf) begin
                        // Commit lands together with the strobe for the APPLY cycle.
                        state_reg      <= APPLY;
                        op_sel_reg     <= pending_reg;
                        op_strobe_reg  <= 1'b1;
                        disp_sel_reg   <= pending_reg;
                        disp_blank_reg <= 1'b0;
                        editing_reg    <= 1'b0;
                    end else if (press_next) begin
                        pending_reg  <= next_op(pending_reg);
                        disp_sel_reg <= next_op(pending_reg);
                        to_cnt_reg   <= '0;
                    end else if (to_cnt_reg == TO_LAST) begin
                        state_reg      <= IDLE;
                        disp_sel_reg   <= op_sel_reg;
                        disp_blank_reg <= 1'b0;
                        editing_reg    <= 1'b0;
                    end
                end
                APPLY: begin
                    state_reg      <= IDLE;
                    disp_sel_reg   <= op_sel_reg;
                    disp_blank_reg <= 1'b0;
                    editing_reg    <= 1'b0;
                end
                default: begin
                    state_reg      <= IDLE;
                    disp_blank_reg <= 1'b0;
                    editing_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign OP_SEL     = op_sel_reg;
    assign DISP_SEL   = disp_sel_reg;
    assign DISP_BLANK = disp_blank_reg;
    assign OP_STROBE  = op_strobe_reg;
    assign EDITING    = editing_reg;

endmodule

// File: tb/tb_controlador_operacao.sv
// Self-checking bench for controlador_operacao with small timing parameters.
module tb_controlador_operacao;
    import controlador_operacao_pkg::*;

    localparam int DEB = 4;
    localparam int BLK = 8;
    localparam int TMO = 64;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       key0   = 1'b1;
    logic       key1   = 1'b1;
    logic       sw9    = 1'b0;
    logic [2:0] op_sel;
    logic [2:0] disp_sel;
    logic       disp_blank;
    logic       op_strobe;
    logic       editing;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    controlador_operacao #(
        .DEBOUNCE_CYCLES(DEB),
        .BLINK_CYCLES   (BLK),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLOCK_50  (clk),
        .RESET_N   (rst_n),
        .KEY0      (key0),
        .KEY1      (key1),
        .SW9       (sw9),
        .OP_SEL    (op_sel),
        .DISP_SEL  (disp_sel),
        .DISP_BLANK(disp_blank),
        .OP_STROBE (op_strobe),
        .EDITING   (editing)
    );

    typedef struct {
        int key;          // 0 = KEY0 confirm, 1 = KEY1 next
        int sw;
        int exp_op;
        int exp_disp;
        int exp_edit;
        int exp_strobes;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Clean press of one key: 10 cycles low, 10 cycles high; counts strobe cycles.
    task automatic press(input int which, output int strobes);
        strobes = 0;
        if (which == 0) key0 = 1'b0;
        else            key1 = 1'b0;
        repeat (10) begin
            step();
            strobes += int'(op_strobe);
        end
        key0 = 1'b1;
        key1 = 1'b1;
        repeat (10) begin
            step();
            strobes += int'(op_strobe);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int pulses;
        int found;

        vecs[0]  = '{1, 0, 1, 2, 1, 0};
        vecs[1]  = '{1, 0, 1, 3, 1, 0};
        vecs[2]  = '{1, 0, 1, 4, 1, 0};
        vecs[3]  = '{1, 0, 1, 5, 1, 0};
        vecs[4]  = '{1, 0, 1, 6, 1, 0};
        vecs[5]  = '{0, 0, 6, 6, 0, 1};
        vecs[6]  = '{1, 0, 6, 7, 1, 0};
        vecs[7]  = '{1, 0, 6, 0, 1, 0};
        vecs[8]  = '{1, 0, 6, 1, 1, 0};
        vecs[9]  = '{0, 0, 1, 1, 0, 1};
        vecs[10] = '{0, 0, 1, 1, 0, 0};
        vecs[11] = '{1, 1, 1, 1, 0, 0};
        vecs[12] = '{1, 0, 1, 2, 1, 0};
        vecs[13] = '{1, 1, 1, 1, 0, 0};

        // Reset state
        repeat (3) step();
        check("rst_op_sel", int'(op_sel), 0);
        check("rst_disp_sel", int'(disp_sel), 0);
        check("rst_disp_blank", int'(disp_blank), 0);
        check("rst_op_strobe", int'(op_strobe), 0);
        check("rst_editing", int'(editing), 0);
        rst_n = 1'b1;
        step();

        // Press latency: first edge sampling the low key is k=0
        key1 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (k < 10) check($sformatf("lat_pulse_k%0d", k), int'(dut.press_pulse[1]), (k == 6) ? 1 : 0);
            if (k == 6) check("lat_editing_k6", int'(editing), 0);
            if (k == 7) begin
                check("lat_editing_k7", int'(editing), 1);
                check("lat_disp_k7", int'(disp_sel), 1);
                check("lat_op_k7", int'(op_sel), 0);
            end
        end
        key1 = 1'b1;
        repeat (10) step();
        check("t1_editing", int'(editing), 1);
        check("t1_disp", int'(disp_sel), 1);
        check("t1_op", int'(op_sel), 0);
        press(0, s);
        check("t1_commit_op", int'(op_sel), 1);
        check("t1_commit_strobes", s, 1);
        check("t1_commit_editing", int'(editing), 0);

        // Table of clean presses
        for (int i = 0; i < 14; i++) begin
            sw9 = vecs[i].sw[0];
            press(vecs[i].key, s);
            sw9 = 1'b0;
            $display("vec %0d key=%0d sw9=%0d op=%0d disp=%0d edit=%0d strobes=%0d",
                     i, vecs[i].key, vecs[i].sw, op_sel, disp_sel, editing, s);
            check($sformatf("vec%0d_op", i), int'(op_sel), vecs[i].exp_op);
            check($sformatf("vec%0d_disp", i), int'(disp_sel), vecs[i].exp_disp);
            check($sformatf("vec%0d_edit", i), int'(editing), vecs[i].exp_edit);
            check($sformatf("vec%0d_strobes", i), s, vecs[i].exp_strobes);
        end

        // Bounce then release: no pulse
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            key1 = ((k / 2) % 2 == 1) ? 1'b1 : 1'b0;
            step();
            pulses += int'(dut.press_pulse[1]);
        end
        key1 = 1'b1;
        repeat (20) begin
            step();
            pulses += int'(dut.press_pulse[1]);
        end
        check("bounce_pulses", pulses, 0);
        check("bounce_editing", int'(editing), 0);

        // Bounce then stable low: exactly one pulse
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            key1 = ((k / 2) % 2 == 1) ? 1'b1 : 1'b0;
            step();
            pulses += int'(dut.press_pulse[1]);
        end
        key1 = 1'b0;
        repeat (12) begin
            step();
            pulses += int'(dut.press_pulse[1]);
        end
        key1 = 1'b1;
        repeat (10) begin
            step();
            pulses += int'(dut.press_pulse[1]);
        end
        check("bounce_low_pulses", pulses, 1);
        check("bounce_low_editing", int'(editing), 1);
        check("bounce_low_disp", int'(disp_sel), 2);
        sw9 = 1'b1;
        step();
        step();
        sw9 = 1'b0;
        check("cancel_editing", int'(editing), 0);
        check("cancel_op", int'(op_sel), 1);
        check("cancel_disp", int'(disp_sel), 1);

        // SW9 coincident with a confirm pulse
        press(1, s);
        check("coinc_enter_disp", int'(disp_sel), 2);
        key0 = 1'b0;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            step();
            if (dut.press_pulse[0]) found = 1;
        end
        check("coinc_pulse_seen", found, 1);
        sw9 = 1'b1;
        step();
        s = int'(op_strobe);
        check("coinc_editing", int'(editing), 0);
        check("coinc_op", int'(op_sel), 1);
        key0 = 1'b1;
        repeat (10) begin
            step();
            s += int'(op_strobe);
        end
        sw9 = 1'b0;
        check("coinc_strobes", s, 0);
        check("coinc_op_after", int'(op_sel), 1);

        // Idle timeout with blink pattern
        key1 = 1'b0;
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            step();
            if (dut.press_pulse[1]) found = 1;
        end
        check("tmo_pulse_seen", found, 1);
        s = 0;
        for (int j = 0; j <= TMO; j++) begin
            step();
            if (j == 3) key1 = 1'b1;
            s += int'(op_strobe);
            check($sformatf("blink_j%0d", j), int'(disp_blank), (j < TMO) ? ((j / BLK) % 2) : 0);
            check($sformatf("tmo_edit_j%0d", j), int'(editing), (j < TMO) ? 1 : 0);
        end
        check("tmo_op", int'(op_sel), 1);
        check("tmo_disp", int'(disp_sel), 1);
        check("tmo_strobes", s, 0);

        // Reset mid-edit with pending = 5
        for (int i = 0; i < 4; i++) press(1, s);
        check("mid_pending_disp", int'(disp_sel), 5);
        check("mid_editing", int'(editing), 1);
        rst_n = 1'b0;
        step();
        check("mid_rst_op", int'(op_sel), 0);
        check("mid_rst_disp", int'(disp_sel), 0);
        check("mid_rst_blank", int'(disp_blank), 0);
        check("mid_rst_strobe", int'(op_strobe), 0);
        check("mid_rst_editing", int'(editing), 0);
        check("mid_rst_state", int'(dut.state_reg), int'(IDLE));
        rst_n = 1'b1;
        step();
        press(1, s);
        check("post_rst_disp", int'(disp_sel), 1);
        check("post_rst_editing", int'(editing), 1);
        check("post_rst_op", int'(op_sel), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
